// File: rtl/instr_encoder_if.sv
// Instruction-encoder bus: field handshake in, instruction-memory write port and status out.
// The master drives fields (bench/boot path); the slave is the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic              finish;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_kind, rs, rt, rd, shamt, funct, imm, finish,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, done, err
    );

    modport slave (
        input  in_valid, in_kind, rs, rt, rd, shamt, funct, imm, finish,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, done, err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words and writes them to consecutive imem addresses.
// Optional INSTR_ENC_PAD_EN: on finish, fill the remaining words with nops before DONE.
//
// state | meaning
// IDLE  | waiting for an instruction or finish
// WRITE | one-cycle imem write of the registered word
// PAD   | nop fill, one word per cycle (INSTR_ENC_PAD_EN only)
// DONE  | loading finished, held until reset
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic           clk_i,
    input  logic           reset_i,
    instr_encoder_if.slave bus
);
`ifdef INSTR_ENC_PAD_EN
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE, S_PAD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;
    logic              pend_q, pend_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              done_q, done_d;
    logic              hs;
    logic              legal;

    assign hs    = bus.in_valid && in_ready_q;
    assign legal = (bus.in_kind <= 3'd5);

    function automatic logic [31:0] encode(input logic [2:0] kind, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] shamt, input logic [5:0] funct,
                                           input logic [15:0] imm);
        logic [5:0] op;
        case (kind)
            3'd1:    op = 6'b100011;
            3'd2:    op = 6'b101011;
            3'd3:    op = 6'b000100;
            3'd4:    op = 6'b000101;
            default: op = 6'b001000;
        endcase
        if (kind == 3'd0) return {6'b000000, rs, rt, rd, shamt, funct};
        return {op, rs, rt, imm};
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            pend_q     <= 1'b0;
            in_ready_q <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            in_ready_q <= in_ready_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (hs && legal) begin
                    wdata_d = encode(bus.in_kind, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.imm);
                    pend_d  = bus.finish;
                    state_d = S_WRITE;
                end else begin
                    if (hs) err_d = 1'b1;
                    if (bus.finish) state_d = S_DONE;
                end
            end
            S_WRITE: begin
                count_d = count_q + 1'b1;
                pend_d  = 1'b0;
                state_d = (pend_q || bus.finish) ? S_DONE : S_IDLE;
            end
`ifdef INSTR_ENC_PAD_EN
            S_PAD: begin
                count_d = count_q + 1'b1;
                if (count_d[ADDR_W]) state_d = S_DONE;
            end
`endif
            default: ;
        endcase
`ifdef INSTR_ENC_PAD_EN
        // finish is redirected through PAD unless memory is already full
        if (state_d == S_DONE && state_q != S_DONE && state_q != S_PAD && !count_d[ADDR_W])
            state_d = S_PAD;
        if (state_d == S_PAD) wdata_d = '0;
`endif
    end

    always_comb begin
        in_ready_d = (state_d == S_IDLE) && !count_d[ADDR_W];
        mem_we_d   = (state_d == S_WRITE);
`ifdef INSTR_ENC_PAD_EN
        if (state_d == S_PAD) mem_we_d = 1'b1;
`endif
        mem_addr_d = count_d[ADDR_W-1:0];
        done_d     = (state_d == S_DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.count     = count_q;
    assign bus.full      = count_q[ADDR_W];
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Sequential MIPS instruction encoder and loader; the inverse of the main control decoder.
- Accepts an instruction class plus register and immediate fields over a valid/ready handshake.
- Packs them into a 32-bit MIPS word (R-type, lw, sw, beq, bne, addi) and writes it to instruction memory at consecutive word addresses.
- Used by the bench and boot path to fill instruction memory before the single-cycle core runs.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; capacity is 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  instruction fields valid
- in_ready  output  1  encoder can accept an instruction
- in_kind  input  3  class: 0=R, 1=lw, 2=sw, 3=beq, 4=bne, 5=addi; 6 and 7 are illegal
- rs  input  5  source register
- rt  input  5  target register
- rd  input  5  destination register (R-type only)
- shamt  input  5  shift amount (R-type only)
- funct  input  6  function code (R-type only)
- imm  input  16  immediate or branch offset (I-type only)
- finish  input  1  end-of-program pulse
- mem_we  output  1  instruction-memory write enable
- mem_addr  output  ADDR_W  write word address
- mem_wdata  output  32  encoded instruction
- count  output  ADDR_W+1  number of words written
- full  output  1  count == 2**ADDR_W
- done  output  1  loading finished
- err  output  1  sticky illegal-kind flag

Behaviour:
- Reset values: in_ready=0 during reset and 1 on the first cycle after; mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, done=0, err=0; state IDLE.
- States are IDLE, WRITE and DONE, plus PAD when the optional feature is enabled.
- IDLE:
  - in_ready = !full.
  - Handshake occurs when in_valid && in_ready at a rising edge.
  - On handshake with a legal kind: register the encoded word into mem_wdata and go to WRITE.
  - On handshake with an illegal kind: set err (sticky), write nothing, stay in IDLE.
  - When in_valid is high while full, nothing is accepted (in_ready stays 0).
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr = count[ADDR_W-1:0], in_ready=0.
  - At the end of the cycle, count increments.
  - Next state is IDLE, or DONE if a finish is pending.
- Latency and throughput: handshake at edge N means mem_we is high during cycle N+1. Throughput is one instruction per two cycles. All outputs are registered.
- Encoding:
  - R-type: {6'b000000, rs, rt, rd, shamt, funct}.
  - I-type: {op, rs, rt, imm}, with op = lw 100011, sw 101011, beq 000100, bne 000101, addi 001000.
  - rd, shamt and funct are ignored for I-type.
- full is asserted once count reaches 2**ADDR_W. There is no wrap-around: further writes are impossible.
- finish handling:
  - finish in IDLE with no handshake: go to DONE next cycle.
  - finish in the same cycle as a handshake: the instruction is written first, then DONE.
  - finish during WRITE: latched as pending.
- DONE: done=1, in_ready=0, mem_we=0. Held until reset.
- Reset asserted in any state, including mid-WRITE: all outputs return to reset values on the next edge and no partial write occurs afterward.

Optional Feature:
- Macro: INSTR_ENC_PAD_EN.
- Defined:
  - finish moves the FSM to PAD instead of DONE, after any pending write completes.
  - In PAD, each cycle: mem_we=1, mem_wdata=32'h00000000 (nop), mem_addr=count; count increments.
  - When full is reached, go to DONE.
  - If already full when finish arrives, go straight to DONE.
- Undefined: PAD state and its logic are absent. Unwritten memory words are left untouched.

Test Plan:
- Reset, then R-type with rs=1, rt=2, rd=3, shamt=0, funct=0x20 -> one cycle later mem_we=1, mem_addr=0, mem_wdata=0x00221820; then count=1.
- Back-to-back lw (rs=17, rt=8, imm=4), sw (rs=29, rt=31, imm=0), addi (rs=0, rt=5, imm=7) -> words 0x8E280004, 0xAFBF0000, 0x20050007 at addresses 0, 1, 2; in_ready low during each WRITE cycle.
- beq then bne with rs=1, rt=2, imm=0xFFFF -> 0x1022FFFF then 0x1422FFFF.
- in_kind=6 with in_valid -> err=1 and stays 1; no mem_we; count unchanged; next legal instruction still written.
- ADDR_W=2: write 4 instructions -> full=1, in_ready=0, count=4; a 5th in_valid causes no write.
- finish together with a handshake -> instruction written, then done=1. With INSTR_ENC_PAD_EN and ADDR_W=2 after 1 word -> zeros written at addresses 1 to 3, then done=1, count=4.
- Reset asserted during WRITE -> next cycle mem_we=0, count=0.
